stage_ex: RTL

- Execute stage sitting directly downstream of the ID/EX pipeline register.
- Consumes ID/EX control and data, and computes ALU results. Multiply is iterative over several cycles.
- Resolves jumps and registers results into the EX/MEM boundary, so the EX/MEM register is folded into this block.
- Asserts stall_out upstream while a multiply is in flight.

---
 rtl/ex_pkg.sv | 47 ++++
 rtl/stage_ex_mul_iter.sv | 59 +++++
 rtl/stage_ex.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage.
package ex_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned MUL_STEP_DEFAULT = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_MUL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

    // Only step sizes that divide 32 into a power-of-two iteration count are supported
    function automatic bit mul_step_legal(input int unsigned step);
        return (step == 1) || (step == 2) || (step == 4) || (step == 8);
    endfunction

    // Single-cycle ALU; MUL is handled by the iterative multiplier
    function automatic logic [XLEN-1:0] alu_calc(input alu_op_t op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        res = '0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLL: res = a << b[4:0];
            ALU_SRL: res = a >> b[4:0];
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/stage_ex_mul_iter.sv
// Iterative shift-add multiplier datapath, MUL_STEP multiplier bits per step.
module mul_iter
    import ex_pkg::*;
#(
    parameter int unsigned MUL_STEP = MUL_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_busy,
    output logic            o_last_c,
    output logic [XLEN-1:0] o_product_c
);

    localparam int unsigned N     = XLEN / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(N);

    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  w_partial;

    // Partial product of the shifted multiplicand and the current multiplier chunk
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < int'(MUL_STEP); j++) begin
            if (r_b[j]) begin
                w_partial = w_partial + (r_a << j);
            end
        end
    end

    assign o_product_c = r_acc + w_partial;
    assign o_last_c    = (r_cnt == '0);

    // Accumulate one chunk per falling edge while busy
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= CNT_W'(N - 1);
        end else if (i_busy) begin
            r_acc <= o_product_c;
            r_a   <= r_a << MUL_STEP;
            r_b   <= r_b >> MUL_STEP;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/stage_ex.sv
// Execute stage with folded EX/MEM register, jump resolution and iterative multiply.
module stage_ex
    import ex_pkg::*;
#(
    parameter int unsigned MUL_STEP = MUL_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  ALUOp_in,
    input  logic        ALUSrc_in,
    input  logic        JumpI_in,
    input  logic        JumpCI_in,
    input  logic        JumpCD_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] RD1_in,
    input  logic [31:0] RD2_in,
    input  logic [31:0] RD3_in,
    input  logic [31:0] num_in,
    input  logic [3:0]  RR3_in,
    output logic        stall_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  RR3_out,
    output logic        MemToReg_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        RegWrite_out,
    output logic        jump_taken_out,
    output logic [31:0] jump_target_out
);

    if (!mul_step_legal(MUL_STEP)) begin : g_bad_step
        $error("stage_ex: MUL_STEP must be 1, 2, 4 or 8");
    end

    ex_state_t   r_state;
    logic [31:0] r_l_store;
    logic [3:0]  r_l_rr3;
    logic        r_l_memtoreg;
    logic        r_l_memread;
    logic        r_l_memwrite;
    logic        r_l_regwrite;
    logic        r_l_taken;
    logic [31:0] r_l_target;

    logic [31:0] w_b;
    logic        w_is_mul;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_start;
    logic        w_busy;
    logic        w_last;
    logic [31:0] w_product;

    assign w_b      = ALUSrc_in ? num_in : RD2_in;
    assign w_is_mul = (alu_op_t'(ALUOp_in) == ALU_MUL);
    assign w_taken  = JumpI_in | (JumpCI_in & (RD1_in == RD2_in)) | (JumpCD_in & (RD1_in != RD2_in));
    assign w_target = pc_in + num_in;
    assign w_start  = (r_state == IDLE) && w_is_mul;
    assign w_busy   = (r_state == BUSY);

    // Stall upstream from MUL acceptance until the final chunk edge; never while in reset
    assign stall_out = rst && (w_start || (w_busy && !w_last));

    mul_iter #(
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_a         (RD1_in),
        .i_b         (w_b),
        .i_busy      (w_busy),
        .o_last_c    (w_last),
        .o_product_c (w_product)
    );

    // FSM plus EX/MEM register; bubbles are emitted while a multiply is in flight
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_l_store       <= '0;
            r_l_rr3         <= '0;
            r_l_memtoreg    <= 1'b0;
            r_l_memread     <= 1'b0;
            r_l_memwrite    <= 1'b0;
            r_l_regwrite    <= 1'b0;
            r_l_taken       <= 1'b0;
            r_l_target      <= '0;
            alu_result_out  <= '0;
            store_data_out  <= '0;
            RR3_out         <= '0;
            MemToReg_out    <= 1'b0;
            MemRead_out     <= 1'b0;
            MemWrite_out    <= 1'b0;
            RegWrite_out    <= 1'b0;
            jump_taken_out  <= 1'b0;
            jump_target_out <= '0;
        end else begin
            alu_result_out  <= '0;
            store_data_out  <= '0;
            RR3_out         <= '0;
            MemToReg_out    <= 1'b0;
            MemRead_out     <= 1'b0;
            MemWrite_out    <= 1'b0;
            RegWrite_out    <= 1'b0;
            jump_taken_out  <= 1'b0;
            jump_target_out <= '0;
            case (r_state)
                IDLE: begin
                    if (w_is_mul) begin
                        r_state      <= BUSY;
                        r_l_store    <= RD3_in;
                        r_l_rr3      <= RR3_in;
                        r_l_memtoreg <= MemToReg_in;
                        r_l_memread  <= MemRead_in;
                        r_l_memwrite <= MemWrite_in;
                        r_l_regwrite <= RegWrite_in;
                        r_l_taken    <= w_taken;
                        r_l_target   <= w_target;
                    end else begin
                        alu_result_out  <= alu_calc(alu_op_t'(ALUOp_in), RD1_in, w_b);
                        store_data_out  <= RD3_in;
                        RR3_out         <= RR3_in;
                        MemToReg_out    <= MemToReg_in;
                        MemRead_out     <= MemRead_in;
                        MemWrite_out    <= MemWrite_in;
                        RegWrite_out    <= RegWrite_in;
                        jump_taken_out  <= w_taken;
                        jump_target_out <= w_target;
                    end
                end
                BUSY: begin
                    if (w_last) begin
                        r_state         <= IDLE;
                        alu_result_out  <= w_product;
                        store_data_out  <= r_l_store;
                        RR3_out         <= r_l_rr3;
                        MemToReg_out    <= r_l_memtoreg;
                        MemRead_out     <= r_l_memread;
                        MemWrite_out    <= r_l_memwrite;
                        RegWrite_out    <= r_l_regwrite;
                        jump_taken_out  <= r_l_taken;
                        jump_target_out <= r_l_target;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
